// File: rtl/pid_multichannel.sv
// pid_multichannel
//   Time-multiplexed PID controller for NCH heater zones sharing one
//   arithmetic datapath. A `start` strobe (accepted only while idle) snapshots
//   all setpoints, measurements and gains. Each channel then takes four
//   cycles: ERR -> TERM -> SUM -> OUT. Saturated power words are written
//   back one channel at a time.
//
//   Optional build macro: PIDMC_DTERM_EN
//     defined   : derivative term with per-channel last_e / primed state
//     undefined : d is always 0, kd is ignored, latency unchanged
//
// Ports
//   clk       clock
//   reset     asynchronous, active-high
//   start     sample strobe, ignored while busy
//   setpoint  NCH*TW packed signed setpoints, channel 0 in LSBs
//   measured  NCH*TW packed signed measured temperatures
//   kp/ki/kd  GW-bit unsigned gains, captured with start
//   busy      high while a sample is being processed
//   done      one-cycle pulse after the last channel is written
//   power     NCH*OW packed unsigned heater power
//   sat       per-channel flag: last output was clamped

module pid_multichannel #(
  parameter int NCH   = 4,
  parameter int TW    = 16,
  parameter int GW    = 12,
  parameter int OW    = 8,
  parameter int IW    = 24,
  parameter int IMAX  = 1048576,
  parameter int SHIFT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NCH*TW-1:0]   setpoint,
  input  logic [NCH*TW-1:0]   measured,
  input  logic [GW-1:0]       kp,
  input  logic [GW-1:0]       ki,
  input  logic [GW-1:0]       kd,
  output logic                busy,
  output logic                done,
  output logic [NCH*OW-1:0]   power,
  output logic [NCH-1:0]      sat
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW = TW + 1;           // error width
  localparam int DW = TW + 2;           // error-difference width
  // Wide enough that p + ki*integ + d can never overflow.
  localparam int RW = GW + IW + TW + 4;

  localparam logic signed [IW:0] IMAX_P = (IW+1)'(IMAX);
  localparam logic signed [IW:0] IMAX_N = -IMAX_P;

  typedef enum logic [2:0] {IDLE, ERR, TERM, SUM, OUT} state_t;

  state_t state, state_next;

  logic [CW-1:0]         ch;
  logic                  last_ch;

  logic signed [TW-1:0]  sp_s [NCH];
  logic signed [TW-1:0]  pv_s [NCH];
  logic [GW-1:0]         kp_s;
  logic [GW-1:0]         ki_s;

  logic signed [IW-1:0]  integ [NCH];

  logic signed [EW-1:0]  e_r;
  logic signed [RW-1:0]  p_r;
  logic signed [RW-1:0]  d_r;
  logic signed [RW-1:0]  raw_r;
  logic signed [IW-1:0]  integ_new;

  logic [OW-1:0]         power_cur;
  logic                  e_pos;
  logic                  e_neg;
  logic signed [IW:0]    integ_sum;
  logic signed [IW-1:0]  integ_upd;
  logic signed [RW-1:0]  p_calc;
  logic signed [RW-1:0]  d_calc;
  logic signed [RW-1:0]  raw_calc;
  logic signed [RW-1:0]  raw_sh;
  logic [OW-1:0]         pwr_calc;
  logic                  sat_calc;

`ifdef PIDMC_DTERM_EN
  logic [GW-1:0]         kd_s;
  logic signed [EW-1:0]  last_e [NCH];
  logic [NCH-1:0]        primed;
  logic signed [DW-1:0]  d_diff;
`else
  logic                  unused_kd;
  assign unused_kd = ^kd;
`endif

  assign last_ch = (ch == CW'(NCH - 1));
  assign busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ERR;
      ERR:     state_next = TERM;
      TERM:    state_next = SUM;
      SUM:     state_next = OUT;
      OUT:     state_next = last_ch ? IDLE : ERR;
      default: state_next = IDLE;
    endcase
  end

  // Shared arithmetic for the current channel
  always_comb begin
    power_cur = power[ch*OW +: OW];
    e_neg     = e_r[EW-1];
    e_pos     = !e_r[EW-1] && (e_r != '0);
    integ_sum = (IW+1)'(integ[ch]) + (IW+1)'(e_r);

    // Anti-windup: freeze the integrator while the output is pinned at a rail
    // and the error would push it further into that rail.
    if ((power_cur == '1 && e_pos) || (power_cur == '0 && e_neg))
      integ_upd = integ[ch];
    else if (integ_sum > IMAX_P)
      integ_upd = IMAX_P[IW-1:0];
    else if (integ_sum < IMAX_N)
      integ_upd = IMAX_N[IW-1:0];
    else
      integ_upd = integ_sum[IW-1:0];

    p_calc = RW'($signed({1'b0, kp_s})) * RW'(e_r);

`ifdef PIDMC_DTERM_EN
    d_diff = DW'(e_r) - DW'(last_e[ch]);
    d_calc = primed[ch] ? RW'($signed({1'b0, kd_s})) * RW'(d_diff) : '0;
`else
    d_calc = '0;
`endif

    raw_calc = p_r + RW'($signed({1'b0, ki_s})) * RW'(integ_new) + d_r;

    raw_sh   = raw_r >>> SHIFT;
    if (raw_r[RW-1]) begin
      pwr_calc = '0;
      sat_calc = 1'b1;
    end else if (|raw_sh[RW-1:OW]) begin
      pwr_calc = '1;
      sat_calc = 1'b1;
    end else begin
      pwr_calc = raw_sh[OW-1:0];
      sat_calc = 1'b0;
    end
  end

  // Datapath and per-channel state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch        <= '0;
      done      <= 1'b0;
      power     <= '0;
      sat       <= '0;
      kp_s      <= '0;
      ki_s      <= '0;
      e_r       <= '0;
      p_r       <= '0;
      d_r       <= '0;
      raw_r     <= '0;
      integ_new <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        sp_s[i]  <= '0;
        pv_s[i]  <= '0;
        integ[i] <= '0;
      end
`ifdef PIDMC_DTERM_EN
      kd_s   <= '0;
      primed <= '0;
      for (int unsigned i = 0; i < NCH; i++) last_e[i] <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NCH; i++) begin
              sp_s[i] <= setpoint[i*TW +: TW];
              pv_s[i] <= measured[i*TW +: TW];
            end
            kp_s <= kp;
            ki_s <= ki;
`ifdef PIDMC_DTERM_EN
            kd_s <= kd;
`endif
            ch <= '0;
          end
        end
        ERR: e_r <= EW'(sp_s[ch]) - EW'(pv_s[ch]);
        TERM: begin
          p_r       <= p_calc;
          d_r       <= d_calc;
          integ_new <= integ_upd;
        end
        SUM: raw_r <= raw_calc;
        OUT: begin
          power[ch*OW +: OW] <= pwr_calc;
          sat[ch]            <= sat_calc;
          integ[ch]          <= integ_new;
`ifdef PIDMC_DTERM_EN
          last_e[ch]         <= e_r;
          primed[ch]         <= 1'b1;
`endif
          if (last_ch) done <= 1'b1;
          else         ch   <= ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_multichannel.sv
// Self-checking bench for pid_multichannel: directed cases plus randomized
// samples checked cycle by cycle against an arithmetic reference model.
module tb_pid_multichannel;

  localparam int NCH   = 4;
  localparam int TW    = 16;
  localparam int GW    = 12;
  localparam int OW    = 8;
  localparam int IW    = 24;
  localparam int IMAX  = 1024;
  localparam int SHIFT = 8;
  localparam longint MAXP = (longint'(1) << OW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NCH*TW-1:0] setpoint;
  logic [NCH*TW-1:0] measured;
  logic [GW-1:0]     kp, ki, kd;
  logic              busy, done;
  logic [NCH*OW-1:0] power;
  logic [NCH-1:0]    sat;

  always #5 clk = ~clk;

  pid_multichannel #(
    .NCH(NCH), .TW(TW), .GW(GW), .OW(OW), .IW(IW), .IMAX(IMAX), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .setpoint(setpoint), .measured(measured),
    .kp(kp), .ki(ki), .kd(kd),
    .busy(busy), .done(done), .power(power), .sat(sat)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  longint m_integ [NCH];
  longint m_laste [NCH];
  bit     m_primed[NCH];
  longint m_pwr   [NCH];
  bit     m_sat   [NCH];
  longint n_pwr   [NCH];
  bit     n_sat   [NCH];

  // Stimulus for the next sample
  longint t_sp[NCH];
  longint t_pv[NCH];
  longint t_kp, t_ki, t_kd;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_integ[i] = 0; m_laste[i] = 0; m_primed[i] = 0;
      m_pwr[i] = 0; m_sat[i] = 0;
    end
  endfunction

  // Computes the new outputs of every channel (applied later on schedule)
  // and commits the internal per-channel state.
  function automatic void model_compute();
    longint e, ni, d, raw, r;
    for (int k = 0; k < NCH; k++) begin
      e = t_sp[k] - t_pv[k];
      if ((m_pwr[k] == MAXP && e > 0) || (m_pwr[k] == 0 && e < 0))
        ni = m_integ[k];
      else begin
        ni = m_integ[k] + e;
        if (ni > IMAX)  ni = IMAX;
        if (ni < -IMAX) ni = -IMAX;
      end
      d = 0;
`ifdef PIDMC_DTERM_EN
      if (m_primed[k]) d = t_kd * (e - m_laste[k]);
`endif
      raw = t_kp * e + t_ki * ni + d;
      if (raw < 0) begin
        n_pwr[k] = 0; n_sat[k] = 1;
      end else begin
        r = raw / (longint'(1) << SHIFT);
        if (r > MAXP) begin n_pwr[k] = MAXP; n_sat[k] = 1; end
        else          begin n_pwr[k] = r;    n_sat[k] = 0; end
      end
      m_integ[k] = ni;
      m_laste[k] = e;
      m_primed[k] = 1;
    end
  endfunction

  function automatic logic [NCH*OW-1:0] exp_power();
    logic [NCH*OW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*OW +: OW] = OW'(m_pwr[k]);
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_sat();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = m_sat[k];
    return r;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < NCH; i++) begin
      setpoint[i*TW +: TW] = TW'(t_sp[i]);
      measured[i*TW +: TW] = TW'(t_pv[i]);
    end
    kp = GW'(t_kp); ki = GW'(t_ki); kd = GW'(t_kd);
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < NCH; i++) begin
      setpoint[i*TW +: TW] = TW'($urandom);
      measured[i*TW +: TW] = TW'($urandom);
    end
    kp = GW'($urandom); ki = GW'($urandom); kd = GW'($urandom);
  endtask

  task automatic set_all(input longint sp, input longint pv);
    for (int i = 0; i < NCH; i++) begin t_sp[i] = sp; t_pv[i] = pv; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_power", power, 0);
    check("rst_sat", sat, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full sample; capture happens at the first posedge after entry.
  // keep=1 leaves start high so the next sample retriggers immediately.
  task automatic run_sample(input bit keep);
    @(negedge clk);
    apply_inputs();
    start = 1'b1;
    model_compute();
    @(posedge clk); #1;
    check("busy_start", busy, 1);
    check("done_start", done, 0);
    for (int c = 1; c <= 4*NCH; c++) begin
      @(negedge clk);
      scramble_inputs();
      if (!keep) start = (c == 5);
      @(posedge clk); #1;
      for (int k = 0; k < NCH; k++)
        if (c == 4*k + 4) begin m_pwr[k] = n_pwr[k]; m_sat[k] = n_sat[k]; end
      check("power", power, exp_power());
      check("sat", sat, exp_sat());
      if (c < 4*NCH) begin
        check("busy_mid", busy, 1);
        check("done_mid", done, 0);
      end else begin
        check("busy_end", busy, 0);
        check("done_end", done, 1);
      end
    end
    if (!keep) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    setpoint = '0; measured = '0; kp = '0; ki = '0; kd = '0;
    t_kp = 0; t_ki = 0; t_kd = 0;
    set_all(0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // P only
    t_kp = 20; t_ki = 0; t_kd = 0;
    set_all(0, 0);
    t_sp[0] = 200; t_pv[0] = 100;
    t_sp[1] = 0;   t_pv[1] = 100;
    run_sample(0);
    check("p_only_ch0", power[7:0], 7);
    check("p_only_sat0", sat[0], 0);
    check("p_only_ch1", power[15:8], 0);
    check("p_only_sat1", sat[1], 1);

    // Saturation with anti-windup, then expose the held integrator
    do_reset();
    t_kp = 100; t_ki = 1; t_kd = 0;
    set_all(1000, 0);
    for (int s = 0; s < 5; s++) begin
      run_sample(0);
      check("sat_power", power[7:0], 255);
      check("sat_flag", sat[0], 1);
    end
    t_kp = 0;
    set_all(0, 0);
    run_sample(0);
    check("windup_held", power[7:0], 3);

    // Integral with clamp at IMAX=1024
    do_reset();
    t_kp = 0; t_ki = 1; t_kd = 0;
    set_all(512, 0);
    run_sample(0); check("integ_1", power[7:0], 2);
    run_sample(0); check("integ_2", power[7:0], 4);
    run_sample(0); check("integ_clamp", power[7:0], 4);

    // Derivative
    do_reset();
    t_kp = 0; t_ki = 0; t_kd = 256;
    set_all(10, 0);
    run_sample(0); check("deriv_unprimed", power[7:0], 0);
    set_all(20, 0);
    run_sample(0);
`ifdef PIDMC_DTERM_EN
    check("deriv_step", power[7:0], 10);
`else
    check("deriv_step", power[7:0], 0);
`endif

    // Reset at edge 6 of a sample; next sample starts unprimed
    set_all(30, 0);
    @(negedge clk);
    apply_inputs();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_power", power, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    set_all(20, 0);
    run_sample(0);
    check("post_rst_deriv", power[7:0], 0);

    // Held start retriggers back to back
    t_kp = 30; t_ki = 2; t_kd = 40;
    set_all(300, 100);
    run_sample(1);
    set_all(100, 300);
    run_sample(1);
    run_sample(0);

    // Randomized samples
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 5) == 0) begin
        t_kp = $urandom_range(0, 4095);
        t_ki = $urandom_range(0, 4095);
        t_kd = $urandom_range(0, 4095);
      end else begin
        t_kp = $urandom_range(0, 80);
        t_ki = $urandom_range(0, 4);
        t_kd = $urandom_range(0, 400);
      end
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          t_sp[i] = longint'($signed(16'($urandom)));
          t_pv[i] = longint'($signed(16'($urandom)));
        end else begin
          t_sp[i] = longint'($urandom_range(0, 4000)) - 2000;
          t_pv[i] = longint'($urandom_range(0, 4000)) - 2000;
        end
      end
      run_sample(($urandom_range(0, 3) == 0) && (s != 39));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pid_multichannel.md
# pid_multichannel

Time-multiplexed, parametrised PID controller for NCH independent heater zones, sharing one arithmetic datapath. On each `start` strobe it snapshots every zone's setpoint and measured temperature, computes P, I and D per channel in sequence, and writes saturated heater power words. It sits between the temperature-sensor sampling logic and the per-zone PWM drivers.

## Interface
- `NCH`, 4, number of channels (1–16)
- `TW`, 16, signed temperature width
- `GW`, 12, unsigned gain width
- `OW`, 8, output power width
- `IW`, 24, signed integral accumulator width
- `IMAX`, 1048576, integral clamp magnitude (< 2^(IW-1))
- `SHIFT`, 8, output scaling right-shift
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  sample strobe; accepted only when idle
- `setpoint`  in  NCH*TW  packed signed setpoints, channel 0 in LSBs
- `measured`  in  NCH*TW  packed signed measured temperatures
- `kp`, `ki`, `kd`  in  GW each  shared gains, captured with `start`
- `busy`  out  1  high while a sample is being processed
- `done`  out  1  one-cycle pulse when all channels are written
- `power`  out  NCH*OW  packed heater power, unsigned
- `sat`  out  NCH  per-channel flag: last output clamped (high or low)

## Operation
- FSM states: IDLE, ERR, TERM, SUM, OUT. The channel index `ch` loops through ERR→TERM→SUM→OUT. After OUT of channel NCH-1 the FSM returns to IDLE; otherwise `ch` increments and the FSM goes to ERR.
- IDLE + `start`: latch `setpoint`, `measured`, `kp`, `ki`, `kd` into snapshot registers; set `ch`=0; go to ERR. A `start` while busy is ignored.
- ERR: e = sp[ch] − pv[ch], TW+1 bits signed.
- TERM:
  - p = kp·e.
  - Integral update with anti-windup:
    - hold if power[ch] = 2^OW−1 and e > 0;
    - hold if power[ch] = 0 and e < 0;
    - otherwise integ[ch] + e, clamped to [−IMAX, +IMAX].
  - d = kd·(e − last_e[ch]). d is forced to 0 if the channel's `primed` bit is clear.
- SUM: raw = p + ki·integ_new + d. Full-precision signed arithmetic; intermediates are sized so no overflow is possible.
- OUT:
  - If raw < 0: power = 0, sat = 1.
  - Else if (raw >>> SHIFT) > 2^OW−1: power = 2^OW−1, sat = 1.
  - Else: power = raw >>> SHIFT, sat = 0.
  - Also write integ[ch], last_e[ch]; set primed[ch].
- Gains are unsigned. Gain value 0 disables that term.

## Timing
- Reset values: `power`=0, `sat`=0, `busy`=0, `done`=0. All integ, last_e, primed, snapshot registers and `ch` are 0; FSM in IDLE.
- `start` sampled high at edge T (in IDLE): `busy` high from T.
- Channel k's `power`/`sat` update at edge T+4k+4.
- `done`=1 and `busy`=0 during the cycle after edge T+4·NCH; the next `start` is accepted at that same edge.
- `start` held high continuously retriggers every 4·NCH+1 cycles.
- Outputs of unprocessed channels hold their previous values during a sample.
- Input changes after the capture edge do not affect the running sample.
- Reset mid-sample: immediately return to the reset state and abandon the partial sample. The next sample treats all channels as unprimed.

## Configuration
- `PIDMC_DTERM_EN` defined: derivative path, per-channel last_e and primed registers are present; behaviour as above.
- Undefined: d ≡ 0; last_e and primed are not implemented; `kd` port is present but ignored; latency is unchanged.

## Test plan
- Latency/handshake, NCH=4: `start` at edge 0 → `done` in the cycle after edge 16. A `start` at edge 5 is ignored. `busy` is high for cycles 0–16.
- P only (kp=20, ki=kd=0), ch0 sp=200 pv=100 → power[0]=7, sat[0]=0. Ch1 sp=0 pv=100 → power[1]=0, sat[1]=1.
- Saturation + anti-windup (kp=100, ki=1), sp=1000 pv=0:
  - sample 1 → power=255, sat=1, integ=1000;
  - samples 2–5 → integ stays 1000.
- Integral (kp=0, ki=1), e=512 constant → power 2, 4, 6 on successive samples. Clamp test: IMAX=1024 → power holds at 4.
- Derivative (kd=256, kp=ki=0):
  - e=10 then e=20 → power 0 (unprimed), then 10;
  - with `PIDMC_DTERM_EN` undefined → 0, 0.
- Reset asserted at edge 6 of a sample → all outputs 0, `busy`=0. The next sample's first derivative is 0.
